// File: rtl/reg_sel_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_sel_pkg
// Brief    : Shared state encodings for the register-select decoder.
// Revision : 1.0
// ============================================================================
package reg_sel_pkg;

    localparam int unsigned c_STATE_W = 2;

    localparam logic [c_STATE_W-1:0] c_ST_IDLE = 2'd0;
    localparam logic [c_STATE_W-1:0] c_ST_SCAN = 2'd1;
    localparam logic [c_STATE_W-1:0] c_ST_DONE = 2'd2;

endpackage : reg_sel_pkg
`default_nettype wire

// File: rtl/onehot_decode.sv
`default_nettype none
// ============================================================================
// Module   : onehot_decode
// Brief    : Combinational binary-to-one-hot decoder.
// Revision : 1.0
// ============================================================================
module onehot_decode #(
    parameter int ADDR_W = 6,
    localparam int OUT_W = 2**ADDR_W
) (
    input  logic [ADDR_W-1:0] i_sel,
    output logic [OUT_W-1:0]  o_onehot
);

    for (genvar k = 0; k < OUT_W; k++) begin : g_bit
        assign o_onehot[k] = (i_sel == ADDR_W'(k));
    end

endmodule : onehot_decode
`default_nettype wire

// File: rtl/reg_sel_decoder.sv
`default_nettype none
// ============================================================================
// Module   : reg_sel_decoder
// Brief    : Registered one-hot select with single-address and sweep modes.
// Revision : 1.0
// ============================================================================
module reg_sel_decoder
    import reg_sel_pkg::*;
#(
    parameter int ADDR_W = 6,
    localparam int OUT_W = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    input  logic              scan_start,
    output logic [OUT_W-1:0]  O,
    output logic              valid,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] c_IDX_LAST = {ADDR_W{1'b1}};

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_state_next;
    logic [ADDR_W-1:0]    r_idx;
    logic [ADDR_W-1:0]    w_idx_next;
    logic [ADDR_W-1:0]    w_idx_inc;
    logic                 w_idx_last;
    logic [ADDR_W-1:0]    w_dec_sel;
    logic [OUT_W-1:0]     w_dec_onehot;

    logic [OUT_W-1:0]     r_o;
    logic                 r_valid;
    logic                 r_busy;
    logic                 r_done;
    logic [OUT_W-1:0]     w_o_next;
    logic                 w_valid_next;
    logic                 w_busy_next;
    logic                 w_done_next;

    assign w_idx_inc  = r_idx + ADDR_W'(1);
    assign w_idx_last = (r_idx == c_IDX_LAST);

    // During a sweep the decoder looks one index ahead, since O is registered.
    assign w_dec_sel = (r_state == c_ST_SCAN) ? w_idx_inc
                     : (scan_start ? '0 : addr);

    onehot_decode #(
        .ADDR_W (ADDR_W)
    ) u_onehot_decode (
        .i_sel    (w_dec_sel),
        .o_onehot (w_dec_onehot)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_idx   <= '0;
            r_o     <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_o     <= w_o_next;
            r_valid <= w_valid_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        case (r_state)
            c_ST_IDLE: begin
                if (scan_start) begin
                    w_state_next = c_ST_SCAN;
                    w_idx_next   = '0;
                end
            end
            c_ST_SCAN: begin
                if (w_idx_last) begin
                    w_state_next = c_ST_DONE;
                end else begin
                    w_idx_next = w_idx_inc;
                end
            end
            c_ST_DONE: begin
                w_state_next = c_ST_IDLE;
                w_idx_next   = '0;
            end
            default: begin
                w_state_next = c_ST_IDLE;
                w_idx_next   = '0;
            end
        endcase
    end

    always_comb begin
        w_o_next     = '0;
        w_valid_next = 1'b0;
        w_busy_next  = 1'b0;
        w_done_next  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (scan_start) begin
                    w_o_next     = w_dec_onehot;
                    w_valid_next = 1'b1;
                    w_busy_next  = 1'b1;
                end else if (en) begin
                    w_o_next     = w_dec_onehot;
                    w_valid_next = 1'b1;
                end
            end
            c_ST_SCAN: begin
                if (w_idx_last) begin
                    w_done_next = 1'b1;
                end else begin
                    w_o_next     = w_dec_onehot;
                    w_valid_next = 1'b1;
                    w_busy_next  = 1'b1;
                end
            end
            default: begin
                w_o_next = '0;
            end
        endcase
    end

    assign O     = r_o;
    assign valid = r_valid;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule : reg_sel_decoder
`default_nettype wire

// File: tb/tb_reg_sel_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_sel_decoder
// Brief    : Directed self-checking bench for reg_sel_decoder (ADDR_W = 6).
// Revision : 1.0
// ============================================================================
module tb_reg_sel_decoder;

    localparam int ADDR_W = 6;
    localparam int OUT_W  = 64;

    logic              clk;
    logic              rst;
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic              scan_start;
    logic [OUT_W-1:0]  O;
    logic              valid;
    logic              busy;
    logic              done;

    int checks   = 0;
    int failures = 0;

    reg_sel_decoder #(
        .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .addr       (addr),
        .scan_start (scan_start),
        .O          (O),
        .valid      (valid),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; addr = '0; scan_start = 1'b0;
        step();
        step();
        checks++; if (O !== 64'h0) begin failures++; $display("FAIL reset_O got=%h exp=%h", O, 64'h0); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        rst = 1'b0;
    endtask

    task automatic test_decode();
        logic [ADDR_W-1:0] addrs [5];
        logic [OUT_W-1:0]  exps  [5];
        addrs[0] = 6'd0;         exps[0] = 64'h0000_0000_0000_0001;
        addrs[1] = 6'b111111;    exps[1] = 64'h8000_0000_0000_0000;
        addrs[2] = 6'b101010;    exps[2] = 64'h0000_0400_0000_0000;
        addrs[3] = 6'b000101;    exps[3] = 64'h0000_0000_0000_0020;
        addrs[4] = 6'b100000;    exps[4] = 64'h0000_0001_0000_0000;
        for (int i = 0; i < 5; i++) begin
            en = 1'b1; addr = addrs[i];
            step();
            checks++; if (O !== exps[i]) begin failures++; $display("FAIL decode_O[%0d] got=%h exp=%h", i, O, exps[i]); end
            checks++; if (valid !== 1'b1) begin failures++; $display("FAIL decode_valid[%0d] got=%b exp=1", i, valid); end
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL decode_busy[%0d] got=%b exp=0", i, busy); end
        end
        en = 1'b0;
        step();
        checks++; if (O !== 64'h0) begin failures++; $display("FAIL idle_O got=%h exp=0", O); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL idle_valid got=%b exp=0", valid); end
    endtask

    task automatic test_scan();
        logic [OUT_W-1:0] exp_o;
        scan_start = 1'b1; en = 1'b0; addr = 6'd7;
        step();
        scan_start = 1'b0;
        exp_o = 64'h1;
        for (int i = 0; i < OUT_W; i++) begin
            checks++; if (O !== exp_o || valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("FAIL scan_cycle[%0d] got O=%h v=%b b=%b d=%b exp O=%h v=1 b=1 d=0",
                         i, O, valid, busy, done, exp_o);
            end
            en         = (i == 30);
            addr       = 6'd5;
            scan_start = (i == 40);
            exp_o      = exp_o << 1;
            step();
        end
        en = 1'b0; scan_start = 1'b0;
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL scan_done got=%b exp=1", done); end
        checks++; if (O !== 64'h0 || valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL scan_done_outputs got O=%h v=%b b=%b exp O=0 v=0 b=0", O, valid, busy);
        end
        // Requests during DONE must be ignored.
        en = 1'b1; scan_start = 1'b1; addr = 6'd3;
        step();
        en = 1'b0; scan_start = 1'b0;
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL post_done_pulse got=%b exp=0", done); end
        checks++; if (O !== 64'h0 || valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL post_done_ignore got O=%h v=%b b=%b exp O=0 v=0 b=0", O, valid, busy);
        end
    endtask

    task automatic test_priority_and_abort();
        scan_start = 1'b1; en = 1'b1; addr = 6'd9;
        step();
        scan_start = 1'b0; en = 1'b0;
        checks++; if (O !== 64'h1) begin failures++; $display("FAIL priority_O got=%h exp=%h", O, 64'h1); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL priority_busy got=%b exp=1", busy); end
        for (int i = 0; i < 20; i++) step();
        checks++; if (O !== 64'h0000_0000_0010_0000) begin
            failures++; $display("FAIL scan_idx20 got=%h exp=%h", O, 64'h0000_0000_0010_0000);
        end
        #2 rst = 1'b1;
        #1;
        checks++; if (O !== 64'h0) begin failures++; $display("FAIL async_rst_O got=%h exp=0", O); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL async_rst_busy got=%b exp=0", busy); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL async_rst_valid got=%b exp=0", valid); end
        #2 rst = 1'b0;
        en = 1'b1; addr = 6'd5;
        step();
        en = 1'b0;
        checks++; if (O !== 64'h20 || valid !== 1'b1) begin
            failures++; $display("FAIL post_rst_decode got O=%h v=%b exp O=%h v=1", O, valid, 64'h20);
        end
        for (int i = 0; i < 70; i++) begin
            checks++; if (done !== 1'b0 || busy !== 1'b0) begin
                failures++; $display("FAIL no_done_after_abort[%0d] got d=%b b=%b exp d=0 b=0", i, done, busy);
            end
            step();
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; addr = '0; scan_start = 1'b0;
        test_reset();
        test_decode();
        test_scan();
        test_priority_and_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    always @(negedge clk) begin
        if (!rst && $countones(O) > 1) begin
            failures++;
            $display("FAIL onehot_violation got=%h exp<=1 bit set", O);
        end
    end

endmodule : tb_reg_sel_decoder
`default_nettype wire
